// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative HI/LO multiply/divide unit
// Shift-add multiply and restoring divide share one accumulator; signs are fixed up in FIX.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);
    localparam int W = WIDTH;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t         state, state_nxt;
    logic [4:0]     cnt;
    logic [2*W-1:0] acc;
    logic [W-1:0]   mag_a, mag_b;
    logic           is_mul, neg_q, neg_r, div0;

    logic           is_arith, op_signed, op_mul, a_neg, b_neg;
    logic [W-1:0]   abs_a, abs_b;
    logic [W:0]     mul_sum, div_trial;
    logic [2*W-1:0] iter_acc, prod;
    logic [W-1:0]   quo, rem;

    assign is_arith  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign op_mul    = (op == OP_MULT) || (op == OP_MULTU);
    assign a_neg     = op_signed && a[W-1];
    assign b_neg     = op_signed && b[W-1];
    assign abs_a     = a_neg ? -a : a;
    assign abs_b     = b_neg ? -b : b;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
    // Divide:   acc = {partial remainder, remaining dividend bits}, shifted left.
    assign mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mag_a} : {(W+1){1'b0}});
    assign div_trial = acc[2*W-1:W-1] - {1'b0, mag_b};

    always_comb begin
        iter_acc = acc;
        if (is_mul)
            iter_acc = {mul_sum, acc[W-1:1]};
        else if (div_trial[W])
            iter_acc = {acc[2*W-2:0], 1'b0};
        else
            iter_acc = {div_trial[W-1:0], acc[W-2:0], 1'b1};
    end

    // A zero divisor leaves quotient all-ones unnegated; remainder sign-restores to a.
    assign prod = neg_q ? -acc : acc;
    assign quo  = (neg_q && !div0) ? -acc[W-1:0] : acc[W-1:0];
    assign rem  = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && is_arith) state_nxt = RUN;
            RUN:     if (cnt == 5'd31) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            acc    <= '0;
            mag_a  <= '0;
            mag_b  <= '0;
            is_mul <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op == OP_MTHI) begin
                            hi <= a;
                        end else if (op == OP_MTLO) begin
                            lo <= a;
                        end else if (is_arith) begin
                            cnt    <= 5'd0;
                            is_mul <= op_mul;
                            mag_a  <= abs_a;
                            mag_b  <= abs_b;
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= a_neg;
                            div0   <= (b == '0);
                            acc    <= op_mul ? {{W{1'b0}}, abs_b} : {{W{1'b0}}, abs_a};
                        end
                    end
                end
                RUN: begin
                    acc <= iter_acc;
                    cnt <= cnt + 5'd1;
                end
                FIX: begin
                    done <= 1'b1;
                    if (is_mul) begin
                        hi <= prod[2*W-1:W];
                        lo <= prod[W-1:0];
                    end else begin
                        hi <= rem;
                        lo <= quo;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - randomized bench for mul_div_unit against an arithmetic model
// The model tracks only remaining latency and the final HI/LO values.
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [31:0] hi, lo;
    logic        busy, done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
    logic [63:0] m_pend = 64'd0;
    int          m_remaining = 0;
    logic        m_done = 1'b0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    // Returns {hi, lo} for an arithmetic op.
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] ux, uy, uq, ur;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            3'd1: return 64'(sx * sy);
            3'd2: return ux * uy;
            3'd3, 3'd4: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (o == 3'd3) begin
                    q = sx / sy;
                    r = sx % sy;
                    return {r[31:0], q[31:0]};
                end
                uq = ux / uy;
                ur = ux % uy;
                return {ur[31:0], uq[31:0]};
            end
            default: return 64'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_hi = 32'd0;
            m_lo = 32'd0;
            m_remaining = 0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_remaining > 0) begin
                m_remaining--;
                if (m_remaining == 0) begin
                    {m_hi, m_lo} = m_pend;
                    m_done = 1'b1;
                end
            end else if (start) begin
                case (op)
                    3'd5: m_hi = a;
                    3'd6: m_lo = a;
                    3'd1, 3'd2, 3'd3, 3'd4: begin
                        m_pend = ref_result(op, a, b);
                        m_remaining = 33;
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("hi", {32'd0, hi}, {32'd0, m_hi});
            check("lo", {32'd0, lo}, {32'd0, m_lo});
            check("busy", {63'd0, busy}, {63'd0, (m_remaining > 0)});
            check("done", {63'd0, done}, {63'd0, m_done});
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] exp);
        int n;
        issue(o, x, y);
        n = 0;
        while (busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        check({name, "_busy_cycles"}, 64'(n), 64'd33);
        check({name, "_done"}, {63'd0, done}, 64'd1);
        check({name, "_hilo"}, {hi, lo}, exp);
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        check("ref_mult",  ref_result(3'd1, 32'hFFFF_FFFE, 32'd7), 64'hFFFF_FFFF_FFFF_FFF2);
        check("ref_multu", ref_result(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        check("ref_div",   ref_result(3'd3, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        check("ref_divu0", ref_result(3'd4, 32'd100, 32'd0), 64'h0000_0064_FFFF_FFFF);
        check("ref_divovf", ref_result(3'd3, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

        rst = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        issue(3'd5, $urandom, 32'd0);
        issue(3'd1, $urandom, $urandom);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_busy_done", {62'd0, busy, done}, 64'd0);

        run_op("mult",   3'd1, 32'hFFFF_FFFE, 32'd7, 64'hFFFF_FFFF_FFFF_FFF2);
        run_op("multu",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_op("div",    3'd3, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu0",  3'd4, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF);
        run_op("divovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);

        issue(3'd2, 32'd3, 32'd5);
        repeat (9) @(negedge clk);
        issue(3'd6, 32'h1234, 32'd0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_busy_done", {62'd0, busy, done}, 64'd0);
        issue(3'd5, 32'hABCD, 32'd0);
        check("mthi_hi", {32'd0, hi}, 64'h0000_ABCD);
        check("mthi_busy", {63'd0, busy}, 64'd0);

        repeat (3000) begin
            start = (($urandom % 4) == 0);
            op = 3'($urandom % 8);
            a = pick();
            b = pick();
            rst = (($urandom % 500) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        start = 1'b0;
        repeat (40) @(negedge clk);
        check("final_idle", {63'd0, busy}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit holding the HI/LO register pair for the CPU's MULT/MULTU/DIV/DIVU/MTHI/MTLO instructions. It takes rs/rt operands from the register-file read stage. Its `hi`/`lo` outputs feed the 32-bit 2:1 result selector that sits ahead of register write-back. The selector chooses between the ALU result and the HI/LO value for MFHI/MFLO. The control unit stalls the pipeline while `busy` is high.

## Interface
- `WIDTH`, 32, operand and HI/LO width; only 32 is supported.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request strobe, sampled on every rising edge.
- `op` input 3: operation select.
  - 3'b001 MULT, 3'b010 MULTU, 3'b011 DIV, 3'b100 DIVU, 3'b101 MTHI, 3'b110 MTLO.
  - Any other code is a no-op.
- `a` input 32: rs operand (multiplicand or dividend; MTHI/MTLO source).
- `b` input 32: rt operand (multiplier or divisor).
- `hi` output 32: HI register.
- `lo` output 32: LO register.
- `busy` output 1: arithmetic operation in progress.
- `done` output 1: one-cycle pulse when a MULT/DIV result has been written to HI/LO.

## Operation
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE. Reset overrides every other input on the same edge. Reset mid-operation aborts the operation and leaves no partial result.
- Accept rule: a request is accepted on an edge where `start`=1, `busy`=0 and `rst`=0.
  - `start` while `busy`=1 is ignored. It is not queued.
  - No-op codes are accepted and change nothing.
- MTHI/MTLO: `hi` (or `lo`) is loaded with `a` on the accept edge. `busy` stays 0 and `done` stays 0.
- MULT/MULTU/DIV/DIVU: the unit latches `a`, `b` and the op on the accept edge. It goes to RUN with `busy`=1.
  - Signed ops take operand magnitudes and record the result signs.
- States:
  - IDLE: waits for an accepted request; arithmetic ops go to RUN.
  - RUN: exactly 32 iterations under a 5-bit counter that counts 0..31.
    - Multiply: shift-add, one multiplier bit per cycle, into a 64-bit accumulator.
    - Divide: restoring; one quotient bit per cycle; 33-bit trial subtract of the partial remainder minus divisor.
    - Goes to FIX after iteration 31.
  - FIX: applies sign correction.
    - Product: negated if the operand signs differ.
    - Quotient: negated if the operand signs differ.
    - Remainder: takes the dividend's sign.
    - Writes the results on the FIX edge:
      - MULT/MULTU: {`hi`,`lo`} = 64-bit product.
      - DIV/DIVU: `lo` = quotient, `hi` = remainder.
    - Goes to IDLE with `done`=1.
- Arithmetic rules:
  - Signed results equal the exact two's-complement 64-bit product, or C-style truncating division.
  - Divide by zero (b=0, signed or unsigned): `lo`=32'hFFFF_FFFF, `hi`=`a` unchanged. Same latency; no exception.
  - DIV 32'h8000_0000 / 32'hFFFF_FFFF: `lo`=32'h8000_0000, `hi`=0.
- `hi`/`lo` hold their old values throughout RUN. They change only on the FIX edge, an MTHI/MTLO edge, or reset.

## Timing
- Accept edge E0: `busy` rises after E0.
- RUN iterations occupy edges E1..E32.
- FIX edge E33: `hi`/`lo` update, `busy` falls, and `done`=1 for the single cycle after E33.
- Total latency: 33 cycles after acceptance; `busy` is high for exactly 33 cycles.
- Back-to-back: a new `start` is accepted on E34, which is the edge where `done`=1 is observed. `done` then clears on that edge.
- MTHI/MTLO latency: the value is visible on `hi`/`lo` one cycle after the accept edge.
- Outputs are registered with no combinational path from inputs to outputs.

## Test plan
- Reset: drive `rst`=1 for 2 cycles from random state -> `hi`=`lo`=0, `busy`=0, `done`=0.
- MULT a=32'hFFFF_FFFE (-2), b=7 -> `busy` high 33 cycles. Then {`hi`,`lo`}=64'hFFFF_FFFF_FFFF_FFF2 and `done` pulses once.
- MULTU a=b=32'hFFFF_FFFF -> `hi`=32'hFFFF_FFFE, `lo`=32'h0000_0001.
- DIV a=-7, b=2 -> `lo`=32'hFFFF_FFFD (-3), `hi`=32'hFFFF_FFFF (-1).
- DIVU a=100, b=0 -> `lo`=32'hFFFF_FFFF, `hi`=100.
- DIV 32'h8000_0000 / -1 -> `lo`=32'h8000_0000, `hi`=0.
- Start MULTU 3×5; on cycle 10 assert `start` with MTLO a=32'h1234 (must be ignored); on cycle 20 assert `rst` -> all outputs 0 next cycle. Then MTHI a=32'hABCD -> `hi`=32'hABCD one cycle later with `busy`=0.
